// File: rtl/mac_alu.sv
// Multiply-accumulate ALU: signed accumulator with LOAD/ADD/MUL/MAC.
// Multiplies run on an iterative shift-add engine behind a Start/Busy/Done handshake.
module mac_alu #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 0,
    parameter int SAT   = 1
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic                    Start,
    input  logic                    Clr,
    input  logic [1:0]              Op,
    input  logic                    UseA,
    input  logic signed [WIDTH-1:0] DataA,
    input  logic signed [WIDTH-1:0] DataB,
    output logic signed [WIDTH-1:0] ACC,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Zero,
    output logic                    Neg,
    output logic                    Ovf
);

    typedef enum logic [1:0] {IDLE, MULT, WB} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_MUL, OP_MAC} op_t;

    localparam int PW = 2 * WIDTH;
    localparam int XW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state, state_next;
    op_t                     op_q;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    mcand;
    logic        [WIDTH-1:0] mplier;
    logic        [CW-1:0]    cnt;

    logic                    accept;
    logic                    last_step;
    logic signed [WIDTH-1:0] x_sel;
    logic signed [PW-1:0]    shifted;
    logic signed [XW-1:0]    wide;
    logic                    res_ovf;
    logic signed [WIDTH-1:0] res;

    assign accept    = (state == IDLE) && Start && !Clr;
    assign last_step = (cnt == CW'(WIDTH - 1));
    // MAC always multiplies DataA; UseA only selects X for LOAD/ADD/MUL.
    assign x_sel     = (Op == OP_MAC || !UseA) ? DataA : ACC;

    assign Busy = (state != IDLE);
    assign Zero = (ACC == '0);
    assign Neg  = ACC[WIDTH-1];

    // Exact wide result: ADD/LOAD straight from the inputs, MUL/MAC from the product.
    always_comb begin
        shifted = prod >>> FRAC;
        wide    = '0;
        if (state == WB) begin
            if (op_q == OP_MAC) wide = XW'(ACC) + XW'(shifted);
            else                wide = XW'(shifted);
        end else if (Op == OP_LOAD) begin
            wide = XW'(DataB);
        end else begin
            wide = XW'(x_sel) + XW'(DataB);
        end
    end

    // In range only if every bit above the sign position matches the sign.
    assign res_ovf = !((&wide[XW-1:WIDTH-1]) || !(|wide[XW-1:WIDTH-1]));
    assign res     = (res_ovf && SAT != 0) ? (wide[XW-1] ? MIN_V : MAX_V)
                                           : wide[WIDTH-1:0];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && Op[1]) state_next = MULT;
            MULT:    if (last_step)       state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (Clr) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ACC    <= '0;
            Ovf    <= 1'b0;
            Done   <= 1'b0;
            op_q   <= OP_LOAD;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (Clr) begin
            ACC  <= '0;
            Ovf  <= 1'b0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_t'(Op);
                        if (Op[1]) begin
                            prod   <= '0;
                            mcand  <= PW'(x_sel);
                            mplier <= DataB;
                            cnt    <= '0;
                        end else begin
                            ACC  <= res;
                            Ovf  <= res_ovf;
                            Done <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    // The sign bit of B carries negative weight, so the last step subtracts.
                    if (mplier[0]) prod <= last_step ? prod - mcand : prod + mcand;
                    mcand  <= mcand <<< 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                WB: begin
                    ACC  <= res;
                    Ovf  <= res_ovf;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_alu.sv
// Directed bench for mac_alu: three instances (SAT, FRAC=4, wrap) share one stimulus.
module tb_mac_alu;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       Start, Clr, UseA;
    logic [1:0] Op;
    logic [7:0] DataA, DataB;

    logic [7:0] acc0, acc1, acc2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       zero0, zero1, zero2;
    logic       neg0, neg1, neg2;
    logic       ovf0, ovf1, ovf2;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, MUL = 2'b10, MAC = 2'b11;

    mac_alu #(.WIDTH(8), .FRAC(0), .SAT(1)) d0 (
        .Clock(Clock), .nReset(nReset), .Start(Start), .Clr(Clr), .Op(Op), .UseA(UseA),
        .DataA(DataA), .DataB(DataB), .ACC(acc0), .Busy(busy0), .Done(done0),
        .Zero(zero0), .Neg(neg0), .Ovf(ovf0));

    mac_alu #(.WIDTH(8), .FRAC(4), .SAT(1)) d1 (
        .Clock(Clock), .nReset(nReset), .Start(Start), .Clr(Clr), .Op(Op), .UseA(UseA),
        .DataA(DataA), .DataB(DataB), .ACC(acc1), .Busy(busy1), .Done(done1),
        .Zero(zero1), .Neg(neg1), .Ovf(ovf1));

    mac_alu #(.WIDTH(8), .FRAC(0), .SAT(0)) d2 (
        .Clock(Clock), .nReset(nReset), .Start(Start), .Clr(Clr), .Op(Op), .UseA(UseA),
        .DataA(DataA), .DataB(DataB), .ACC(acc2), .Busy(busy2), .Done(done2),
        .Zero(zero2), .Neg(neg2), .Ovf(ovf2));

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic usea,
                         input logic [7:0] a, input logic [7:0] b);
        Op = op; UseA = usea; DataA = a; DataB = b; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done0, 1'b1);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic usea,
                       input logic [7:0] a, input logic [7:0] b);
        issue(op, usea, a, b);
        wait_done(tag);
    endtask

    initial begin
        int pulses;
        nReset = 1'b0; Start = 1'b0; Clr = 1'b0; UseA = 1'b0;
        Op = LOAD; DataA = '0; DataB = '0;
        #12;
        check("rst_acc",  acc0,  8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_zero", zero0, 1'b1);
        check("rst_neg",  neg0,  1'b0);
        check("rst_ovf",  ovf0,  1'b0);
        nReset = 1'b1;
        tick();

        // LOAD then ADD: single-cycle, Done right after the Start edge
        issue(LOAD, 1'b0, 8'h00, 8'h05);
        check("load_done", done0, 1'b1);
        check("load_busy", busy0, 1'b0);
        check("load_acc",  acc0,  8'h05);
        tick();
        check("load_done_pulse", done0, 1'b0);
        issue(ADD, 1'b1, 8'h00, 8'h03);
        check("add_done", done0, 1'b1);
        check("add_busy", busy0, 1'b0);
        check("add_acc",  acc0,  8'h08);
        check("add_zero", zero0, 1'b0);
        check("add_neg",  neg0,  1'b0);

        // MUL timing with ignored Start pulses while busy
        tick();
        issue(MUL, 1'b0, 8'hFD, 8'h05);
        check("mul_busy_t0", busy0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            Start = 1'b1; Op = LOAD; DataB = 8'h55; DataA = 8'h11;
            tick();
            check("mul_busy", busy0, 1'b1);
            check("mul_nodone", done0, 1'b0);
        end
        Start = 1'b0;
        tick();
        check("mul_done", done0, 1'b1);
        check("mul_busy_end", busy0, 1'b0);
        check("mul_acc", acc0, 8'hF1);
        check("mul_neg", neg0, 1'b1);
        check("mul_ovf", ovf0, 1'b0);
        tick();
        check("mul_acc_hold", acc0, 8'hF1);

        // Saturating and wrapping multiplies
        run("sat_pp", MUL, 1'b0, 8'h64, 8'h64);
        check("sat_pp_acc", acc0, 8'h7F);
        check("sat_pp_ovf", ovf0, 1'b1);
        check("wrap_pp_acc", acc2, 8'h10);
        check("wrap_pp_ovf", ovf2, 1'b1);
        run("sat_np", MUL, 1'b0, 8'h80, 8'h7F);
        check("sat_np_acc", acc0, 8'h80);
        check("sat_np_ovf", ovf0, 1'b1);
        run("sat_nn", MUL, 1'b0, 8'h80, 8'h80);
        check("sat_nn_acc", acc0, 8'h7F);
        check("sat_nn_ovf", ovf0, 1'b1);

        // ADD overflow: saturate vs wrap
        run("ld7f", LOAD, 1'b0, 8'h00, 8'h7F);
        check("ld7f_ovf", ovf0, 1'b0);
        run("addov", ADD, 1'b1, 8'h00, 8'h01);
        check("addov_sat_acc", acc0, 8'h7F);
        check("addov_sat_ovf", ovf0, 1'b1);
        check("addov_wrap_acc", acc2, 8'h80);
        check("addov_wrap_ovf", ovf2, 1'b1);
        check("addov_wrap_neg", neg2, 1'b1);

        // MAC, second one started in the Done cycle of the first
        run("ld0a", LOAD, 1'b0, 8'h00, 8'h0A);
        run("mac1", MAC, 1'b1, 8'h04, 8'hFE);
        check("mac1_acc", acc0, 8'h02);
        check("mac1_ovf", ovf0, 1'b0);
        run("mac2", MAC, 1'b1, 8'h04, 8'hFE);
        check("mac2_acc", acc0, 8'hFA);
        check("mac2_neg", neg0, 1'b1);

        // Fixed point on the FRAC=4 instance
        run("fx1", MUL, 1'b0, 8'h18, 8'h28);
        check("fx1_acc", acc1, 8'h3C);
        check("fx1_ovf", ovf1, 1'b0);
        run("fx2", MUL, 1'b0, 8'hF8, 8'h01);
        check("fx2_acc", acc1, 8'hFF);
        check("fx2_neg", neg1, 1'b1);
        check("fx1_int_sat", acc0, 8'hF8);

        // Clr three cycles into a MUL
        run("pre_clr", MUL, 1'b0, 8'h64, 8'h64);
        check("pre_clr_ovf", ovf0, 1'b1);
        issue(MUL, 1'b0, 8'h03, 8'h03);
        tick();
        tick();
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        check("clr_acc",  acc0,  8'h00);
        check("clr_busy", busy0, 1'b0);
        check("clr_done", done0, 1'b0);
        check("clr_ovf",  ovf0,  1'b0);
        check("clr_zero", zero0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0) pulses++;
        end
        check("clr_no_done", pulses, 0);

        // Async reset mid-MUL, then a fresh MUL
        run("ld33", LOAD, 1'b0, 8'h00, 8'h33);
        issue(MUL, 1'b0, 8'h05, 8'h05);
        tick();
        tick();
        #2;
        nReset = 1'b0;
        #1;
        check("arst_acc",  acc0,  8'h00);
        check("arst_busy", busy0, 1'b0);
        check("arst_done", done0, 1'b0);
        check("arst_zero", zero0, 1'b1);
        #2;
        nReset = 1'b1;
        tick();
        run("post_rst", MUL, 1'b0, 8'h07, 8'hFE);
        check("post_rst_acc", acc0, 8'hF2);
        check("post_rst_neg", neg0, 1'b1);
        check("post_rst_ovf", ovf0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_alu.md
Name: mac_alu

Overview:
Parametrised multiply-accumulate ALU for the next picoMips datapath generation. It holds a WIDTH-bit signed accumulator and supports four operations: load, add, fixed-point multiply and multiply-accumulate. Multiplies run on an iterative shift-add engine, so the controller uses a Start/Busy/Done handshake. Results can optionally saturate, and Zero/Neg/Ovf flags are produced for branch logic.

Parameters:
WIDTH, 8, operand and accumulator width in bits (>=4)
FRAC, 0, fractional bits; product arithmetic-shifted right by FRAC (0 <= FRAC < WIDTH)
SAT, 1, 1 = saturate on overflow, 0 = wrap (two's complement)

Ports:
Clock  input  1  rising-edge clock
nReset  input  1  asynchronous active-low reset
Start  input  1  request operation; sampled only when Busy=0
Clr  input  1  synchronous clear/abort
Op  input  2  00 LOAD, 01 ADD, 10 MUL, 11 MAC
UseA  input  1  X operand = ACC when 1, DataA when 0 (LOAD/ADD/MUL)
DataA  input  WIDTH  signed operand A
DataB  input  WIDTH  signed operand B
ACC  output  WIDTH  signed accumulator
Busy  output  1  multi-cycle operation in progress
Done  output  1  one-cycle pulse: ACC/flags written this edge
Zero  output  1  ACC == 0
Neg  output  1  ACC[WIDTH-1]
Ovf  output  1  last write overflowed (saturated or wrapped)

Behaviour:
- Reset (async, nReset=0): ACC=0, Busy=0, Done=0, Zero=1, Neg=0, Ovf=0, FSM=IDLE. Reset mid-operation discards the operation.
- FSM states: IDLE, MULT, WB.
- IDLE, Start=1, Clr=0: latch Op, X, DataA, DataB.
  - LOAD/ADD complete at that same edge; ACC is written and Done=1 in the following cycle; Busy stays 0.
  - MUL/MAC go to MULT with Busy=1 and iteration count 0.
- Operation definitions:
  - LOAD: ACC <= DataB. Ovf=0.
  - ADD: ACC <= X + DataB. The WIDTH+1-bit exact sum is saturated or wrapped.
  - MUL: P = X * DataB, exact signed 2*WIDTH bits. R = P >>> FRAC (floor). R is saturated or wrapped to WIDTH.
  - MAC: R = ACC + ((DataA * DataB) >>> FRAC), computed exactly, then saturated or wrapped. UseA is ignored.
- MULT: one partial-product step per edge, WIDTH edges in total. The final step subtracts for the sign bit of B, giving an exact signed product. Then go to WB.
- WB: write ACC and flags, Done=1 for that cycle, Busy=0, return to IDLE.
- Latency:
  - Start sampled at edge t.
  - Busy=1 after edges t .. t+WIDTH.
  - ACC is written and Done is high after edge t+WIDTH+1.
  - Busy and Done are never both 1.
- Start while Busy=1 is ignored; the in-flight operation is unaffected. Back-to-back operations are allowed: Start in the Done cycle is accepted.
- Overflow: Ovf=1 if the exact result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT=1: clamp to the nearest bound.
  - SAT=0: keep the low WIDTH bits.
  - Ovf is rewritten on every ACC write; it is not sticky.
- Zero and Neg always reflect the current ACC and update on every ACC write.
- Clr (priority over Start, any state): ACC=0, Ovf=0, FSM=IDLE, Busy=0, Done=0. An aborted multiply produces no Done.
- Operands are latched, so DataA/DataB/Op/UseA may change freely while Busy=1.

Test Plan:
- Use WIDTH=8, FRAC=0, SAT=1 unless stated.
- LOAD/ADD: LOAD DataB=0x05, then ADD UseA=1 DataB=0x03 -> ACC=0x08; Done one cycle after each Start; Busy stays 0; Zero=0, Neg=0.
- MUL timing: MUL UseA=0 DataA=0xFD (-3) DataB=0x05 -> Busy high for 9 cycles, then Done with ACC=0xF1 (-15), Neg=1, Ovf=0; Start pulses during Busy are ignored.
- Saturation:
  - 100*100 -> ACC=0x7F, Ovf=1.
  - -128*127 -> 0x80, Ovf=1.
  - -128*-128 -> 0x7F, Ovf=1.
  - ADD 0x7F+0x01 -> 0x7F, Ovf=1.
  - With SAT=0, the ADD instead gives 0x80, Ovf=1.
- MAC: LOAD 0x0A, then MAC DataA=0x04 DataB=0xFE -> ACC=0x02, Ovf=0. Repeat the MAC -> ACC=0xFA (-6), Neg=1.
- Fixed point, FRAC=4: MUL 0x18 (1.5) * 0x28 (2.5) -> ACC=0x3C (3.75). Also 0xF8 (-0.5) * 0x01 -> 0xFF (floor).
- Abort/reset:
  - Clr asserted 3 cycles into a MUL -> ACC=0, Busy=0 next cycle, no Done pulse.
  - nReset pulsed mid-MUL -> all outputs at reset values immediately; a new MUL then completes normally.
